fib_sched: RTL and testbench
============================

# fib_sched

Round-robin scheduler that shares a single Fibonacci core among NUM_REQ requesters. Each requester presents an index n with a level request. The scheduler picks one requester, pulses go on the core with that n, and waits for done. It then returns result and overflow to that requester with a one-cycle response strobe. A watchdog faults the block if the core never completes. The block sits between the requester fabric and the Fibonacci datapath instance.

## Interface
- NUM_REQ, default 4: number of requesters, ≥2.
- INPUT_WIDTH, default 6: width of each n.
- OUTPUT_WIDTH, default 32: width of result.
- TIMEOUT, default 1024: maximum cycles in WAIT before fault, ≥4.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  NUM_REQ  level request per requester. Held high until that requester's resp_valid, then low in the following cycle.
- req_n  in  NUM_REQ*INPUT_WIDTH  packed n values; slice i = requester i. Stable while req[i] is high.
- grant  out  NUM_REQ  one-hot; identifies the requester being served, from ISSUE through RESP.
- resp_valid  out  NUM_REQ  one-cycle strobe to the served requester.
- resp_result  out  OUTPUT_WIDTH  result; valid with resp_valid.
- resp_overflow  out  1  core overflow flag; valid with resp_valid.
- fault  out  1  sticky watchdog fault.
- fib_go  out  1  core go.
- fib_n  out  INPUT_WIDTH  core n.
- fib_result  in  OUTPUT_WIDTH  core result.
- fib_overflow  in  1  core overflow.
- fib_done  in  1  core done. Cleared the cycle after go is sampled; held high until the next go.

## Operation
- Reset values: all outputs 0, state IDLE, priority pointer 0, captured id/n 0, watchdog counter 0.
- IDLE
  - If fault=1, stay in IDLE and ignore req.
  - Else, if any req is high, select the first set bit at or after the pointer, wrapping modulo NUM_REQ.
  - Capture its id and its req_n slice, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle)
  - grant[id]=1, fib_go=1, fib_n = captured n.
  - Clear the watchdog counter, then go to WAIT.
- WAIT
  - fib_go=0; fib_n and grant are held.
  - If fib_done=1, capture fib_result and fib_overflow, then go to RESP.
  - Else increment the watchdog. When the counter reaches TIMEOUT-1 with fib_done still 0, set fault=1, drop grant, and go to IDLE; no resp_valid is issued.
- RESP (1 cycle)
  - resp_valid[id]=1, with captured resp_result and resp_overflow.
  - Pointer ← (id+1) mod NUM_REQ, then go to IDLE. grant drops on exit.
- fib_go is high for exactly one cycle per job. It is never high in WAIT, so the core sees go low before it asserts done.
- The captured n is used, never live req_n. A change on req_n after capture has no effect on the job in progress.
- Requests that drop before they are selected are simply not served. A requester whose req is low in IDLE is skipped.
- Only the served requester's resp_valid bit toggles. resp_result and resp_overflow hold their last values between strobes.
- fault clears only on rst.

## Timing
- req[i] rises in IDLE cycle t → ISSUE (fib_go=1) in t+1 → WAIT from t+2.
- fib_done sampled high in cycle d → resp_valid in d+1 → IDLE in d+2.
- Minimum gap between successive fib_go pulses is 4 cycles.
- Fairness: with all NUM_REQ requests held high continuously, every requester is served exactly once per NUM_REQ consecutive jobs.
- Because fib_done is registered in the core and cleared on the go edge, fib_done in the first WAIT cycle reflects the new job. A stale done from the previous job is never observed.
- rst mid-operation (any state): the scheduler returns to reset values immediately. No resp_valid is issued for the aborted job. The core shares rst, so the next job starts cleanly.
- Simultaneous events:
  - A req rising in the RESP cycle is considered in the following IDLE cycle, with the updated pointer.
  - A req falling during ISSUE or WAIT does not abort the job.

## Test plan
- Single request: req[2]=1, n=10 → fib_go one cycle, fib_n=10. Then resp_valid=4'b0100 with resp_result=55 and resp_overflow=0, one cycle after fib_done.
- Simultaneous requests: req=4'b1011, n={7,–,3,5}, all held until served → service order 0,1,3. Results 5, 2, 13, with exactly one resp_valid bit per job.
- Round-robin wrap: pointer=3 after serving 2, req=4'b1001 → requester 3 served before 0. Then with req=4'b1111 continuously, the next four jobs serve 0,1,2,3 in order.
- Edge n: n=0 → result 0. n=1 → result 0 or 1 per the core's convention, passed through unchanged. n=63 with OUTPUT_WIDTH=32 → resp_overflow=1.
- Watchdog: stub core that never raises fib_done, TIMEOUT=16 → fault=1 exactly 16 cycles after entering WAIT. No resp_valid, and a later req is ignored until rst.
- Reset mid-WAIT: assert rst 5 cycles into a job → all outputs 0 asynchronously. The next request after rst completes with the correct result.

Source files
------------

// File: rtl/fib_sched_if.sv
// rtl/fib_sched_if.sv - Requester fabric and Fibonacci core signal bundle for fib_sched
interface fib_sched_if #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ*INPUT_WIDTH-1:0] req_n;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [OUTPUT_WIDTH-1:0]        resp_result;
    logic                           resp_overflow;
    logic                           fib_go;
    logic [INPUT_WIDTH-1:0]         fib_n;
    logic [OUTPUT_WIDTH-1:0]        fib_result;
    logic                           fib_overflow;
    logic                           fib_done;

    modport slave (
        input  req, req_n, fib_result, fib_overflow, fib_done,
        output grant, resp_valid, resp_result, resp_overflow, fib_go, fib_n
    );

    modport master (
        output req, req_n, fib_result, fib_overflow, fib_done,
        input  grant, resp_valid, resp_result, resp_overflow, fib_go, fib_n
    );
endinterface

// File: rtl/fib_sched.sv
// rtl/fib_sched.sv - Round-robin scheduler sharing one Fibonacci core among NUM_REQ requesters
module fib_sched #(
    parameter int NUM_REQ      = 4,
    parameter int INPUT_WIDTH  = 6,
    parameter int OUTPUT_WIDTH = 32,
    parameter int TIMEOUT      = 1024
) (
    input  logic          clk,
    input  logic          rst,
    fib_sched_if.slave    bus,
    output logic          fault
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ID_W-1:0]         ptr;
    logic [ID_W-1:0]         id;
    logic [ID_W-1:0]         pick_id;
    logic                    pick_vld;
    logic [ID_W:0]           sum;
    logic [INPUT_WIDTH-1:0]  n_q;
    logic [CNT_W-1:0]        wd_cnt;
    logic                    wd_expire;
    logic [OUTPUT_WIDTH-1:0] result_q;
    logic                    overflow_q;
    logic [NUM_REQ-1:0]      id_onehot;
    logic [INPUT_WIDTH-1:0]  n_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign n_arr[g] = bus.req_n[g*INPUT_WIDTH +: INPUT_WIDTH];
    end

    // Scan from the highest offset down so the nearest request at/after ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        sum      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ)) begin
                sum = sum - (ID_W+1)'(NUM_REQ);
            end
            if (bus.req[sum[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = sum[ID_W-1:0];
            end
        end
    end

    assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));
    assign id_onehot = NUM_REQ'(1) << id;

    always_comb begin
        state_nxt      = state;
        bus.fib_go     = 1'b0;
        bus.grant      = '0;
        bus.resp_valid = '0;
        case (state)
            IDLE: begin
                if (!fault && pick_vld) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.fib_go = 1'b1;
                bus.grant  = id_onehot;
                state_nxt  = WAIT;
            end
            WAIT: begin
                bus.grant = id_onehot;
                if (bus.fib_done) begin
                    state_nxt = RESP;
                end else if (wd_expire) begin
                    state_nxt = IDLE;
                end
            end
            RESP: begin
                bus.grant      = id_onehot;
                bus.resp_valid = id_onehot;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.fib_n         = n_q;
    assign bus.resp_result   = result_q;
    assign bus.resp_overflow = overflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            id         <= '0;
            n_q        <= '0;
            wd_cnt     <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (!fault && pick_vld) begin
                        id  <= pick_id;
                        n_q <= n_arr[pick_id];
                    end
                end
                ISSUE: wd_cnt <= '0;
                WAIT: begin
                    if (bus.fib_done) begin
                        result_q   <= bus.fib_result;
                        overflow_q <= bus.fib_overflow;
                    end else if (wd_expire) begin
                        fault <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                RESP: ptr <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fib_sched.sv
// tb/tb_fib_sched.sv - Randomized self-checking bench for fib_sched with a job-level reference model
module tb_fib_sched;
    localparam int NR = 4;
    localparam int IW = 6;
    localparam int OW = 32;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fault;

    fib_sched_if #(.NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW)) bus ();

    fib_sched #(.NUM_REQ(NR), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .fault (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fib(input int n);
        logic [63:0] a, b, t;
        a = 64'd0;
        b = 64'd1;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Core stub: done cleared on go, raised core_lat cycles later unless core_dead.
    int              core_lat  = 3;
    bit              core_dead = 1'b0;
    int              c_cnt;
    logic            c_busy;
    logic [IW-1:0]   c_n;
    logic [63:0]     c_f;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.fib_done     <= 1'b0;
            bus.fib_result   <= '0;
            bus.fib_overflow <= 1'b0;
            c_busy           <= 1'b0;
            c_cnt            <= 0;
            c_n              <= '0;
        end else if (bus.fib_go) begin
            bus.fib_done   <= 1'b0;
            bus.fib_result <= OW'($urandom);
            c_busy         <= 1'b1;
            c_cnt          <= core_lat;
            c_n            <= bus.fib_n;
        end else if (c_busy && !core_dead) begin
            if (c_cnt <= 1) begin
                c_f = fib(int'(c_n));
                bus.fib_done     <= 1'b1;
                bus.fib_result   <= c_f[OW-1:0];
                bus.fib_overflow <= ((c_f >> OW) != 64'd0);
                c_busy           <= 1'b0;
            end else begin
                c_cnt <= c_cnt - 1;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state: which job is in flight and what the pointer should be.
    int            ptr_m;
    bit            job_act;
    int            job_id;
    logic [IW-1:0] job_n;
    int            go_cyc;
    int            resp_cyc;
    int            last_go;
    bit            done_seen;
    bit            fault_m;
    bit            idle_prev;
    int            rsp_id;
    logic [OW-1:0] last_res;
    logic          last_ovf;
    int            served_q[$];
    logic [OW-1:0] res_q[$];
    logic          ovf_q[$];

    function automatic logic [NR-1:0] onehot(input int i);
        return NR'(1) << i;
    endfunction

    function automatic int rr_pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            if (v[(p + k) % NR]) return (p + k) % NR;
        end
        return -1;
    endfunction

    function automatic int obs_id(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_n(input int i, input logic [IW-1:0] v);
        bus.req_n[i*IW +: IW] = v;
    endtask

    task automatic reset_model();
        ptr_m     = 0;
        job_act   = 1'b0;
        done_seen = 1'b0;
        fault_m   = 1'b0;
        idle_prev = 1'b1;
        last_go   = -100;
        last_res  = '0;
        last_ovf  = 1'b0;
        rsp_id    = -1;
    endtask

    task automatic monitor();
        bit            exp_go;
        bit            is_resp;
        logic [63:0]   f;
        logic [OW-1:0] exp_res;
        logic          exp_ovf;
        rsp_id  = -1;
        exp_go  = idle_prev && !fault_m && (bus.req != '0);
        is_resp = job_act && done_seen && (cyc == resp_cyc);
        exp_res = last_res;
        exp_ovf = last_ovf;
        if (is_resp) begin
            f       = fib(int'(job_n));
            exp_res = f[OW-1:0];
            exp_ovf = ((f >> OW) != 64'd0);
        end
        check("fib_go", bus.fib_go, exp_go);
        check("resp_valid", bus.resp_valid, is_resp ? onehot(job_id) : '0);
        check("resp_result", bus.resp_result, exp_res);
        check("resp_overflow", bus.resp_overflow, exp_ovf);
        if (exp_go && bus.fib_go) begin
            job_id    = rr_pick(bus.req, ptr_m);
            job_n     = bus.req_n[job_id*IW +: IW];
            job_act   = 1'b1;
            done_seen = 1'b0;
            go_cyc    = cyc;
            check("go_gap_ok", (cyc - last_go) >= 4, 1);
            last_go   = cyc;
            check("grant_issue", bus.grant, onehot(job_id));
            check("fib_n_issue", bus.fib_n, job_n);
        end else if (job_act && !done_seen && cyc == go_cyc + TO + 1) begin
            fault_m = 1'b1;
            job_act = 1'b0;
            check("grant_after_fault", bus.grant, 0);
        end else if (job_act) begin
            check("grant_hold", bus.grant, onehot(job_id));
            check("fib_n_hold", bus.fib_n, job_n);
            if (is_resp) begin
                served_q.push_back(obs_id(bus.resp_valid));
                res_q.push_back(bus.resp_result);
                ovf_q.push_back(bus.resp_overflow);
                last_res    = exp_res;
                last_ovf    = exp_ovf;
                ptr_m       = (job_id + 1) % NR;
                rsp_id      = job_id;
                bus.req[job_id] = 1'b0;
                job_act     = 1'b0;
            end else if (!done_seen && bus.fib_done) begin
                done_seen = 1'b1;
                resp_cyc  = cyc + 1;
            end
        end else begin
            check("grant_idle", bus.grant, 0);
        end
        check("fault", fault, fault_m);
        idle_prev = !job_act && !is_resp;
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        if (!rst) monitor();
    endtask

    task automatic wait_resp(input string tag, input int budget);
        int n0;
        int k;
        n0 = served_q.size();
        k  = 0;
        while (served_q.size() == n0 && k < budget) begin
            step();
            k++;
        end
        check({tag, "_in_time"}, served_q.size() != n0, 1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, bus.grant, 0);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
        check({tag, "_resp_result"}, bus.resp_result, 0);
        check({tag, "_resp_overflow"}, bus.resp_overflow, 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_fib_go"}, bus.fib_go, 0);
        check({tag, "_fib_n"}, bus.fib_n, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst     = 1'b1;
        bus.req = '0;
        #1 check_zero("reset");
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        reset_model();
    endtask

    int            edge_n   [5] = '{0, 1, 47, 48, 63};
    logic [OW-1:0] edge_res [5] = '{32'd0, 32'd1, 32'd2971215073, 32'd512559680, 32'd3350226146};
    logic          edge_ovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int            exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        int r;
        int k;
        int wd_go;
        int fault_cyc;
        int base;
        bus.req   = '0;
        bus.req_n = '0;
        reset_model();
        do_reset();

        // Single request
        core_lat = 4;
        set_n(2, 6'd10);
        bus.req[2] = 1'b1;
        wait_resp("single", 40);
        check("single_id", served_q[$], 2);
        check("single_result", res_q[$], 55);
        check("single_ovf", ovf_q[$], 0);
        step();

        // Pointer sits at 3: requester 3 beats 0, then all four in order twice
        set_n(3, 6'd4);
        set_n(0, 6'd6);
        bus.req = 4'b1001;
        wait_resp("wrap_first", 40);
        check("wrap_first_id", served_q[$], 3);
        step();
        for (int i = 1; i < NR; i++) set_n(i, IW'(i + 8));
        bus.req = 4'b1111;
        base = served_q.size();
        for (int j = 0; j < 8; j++) begin
            wait_resp("rr", 40);
            if (j < 4) begin
                r = served_q[$];
                step();
                bus.req[r] = 1'b1;
            end
        end
        for (int j = 0; j < 8; j++) check("rr_order", served_q[base + j], exp_order[j]);
        step();

        // Simultaneous requests with distinct n
        set_n(0, 6'd5);
        set_n(1, 6'd3);
        set_n(3, 6'd7);
        bus.req = 4'b1011;
        base = served_q.size();
        for (int j = 0; j < 3; j++) wait_resp("simul", 40);
        check("simul_id0", served_q[base], 0);
        check("simul_id1", served_q[base + 1], 1);
        check("simul_id2", served_q[base + 2], 3);
        check("simul_res0", res_q[base], 5);
        check("simul_res1", res_q[base + 1], 2);
        check("simul_res2", res_q[base + 2], 13);
        step();

        // Edge values of n, including overflow
        for (int j = 0; j < 5; j++) begin
            r = $urandom_range(0, NR - 1);
            set_n(r, IW'(edge_n[j]));
            bus.req[r] = 1'b1;
            wait_resp("edge", 40);
            check("edge_result", res_q[$], edge_res[j]);
            check("edge_ovf", ovf_q[$], edge_ovf[j]);
            step();
        end

        // Random traffic
        for (int c = 0; c < 500; c++) begin
            step();
            for (int i = 0; i < NR; i++) begin
                if (!bus.req[i] && !(job_act && job_id == i) && i != rsp_id
                    && $urandom_range(0, 5) == 0) begin
                    set_n(i, IW'($urandom));
                    bus.req[i] = 1'b1;
                end
            end
            if (job_act && cyc == go_cyc && $urandom_range(0, 1) == 0) set_n(job_id, IW'($urandom));
            if (job_act && cyc > go_cyc && $urandom_range(0, 15) == 0) bus.req[job_id] = 1'b0;
            core_lat = $urandom_range(1, 10);
        end
        k = 0;
        while ((bus.req != '0 || job_act) && k < 300) begin
            step();
            k++;
        end
        check("drain_done", (bus.req == '0) && !job_act, 1);

        // Watchdog: core never completes
        core_dead = 1'b1;
        base = served_q.size();
        set_n(1, 6'd9);
        bus.req[1] = 1'b1;
        k = 0;
        fault_cyc = -1;
        while (fault !== 1'b1 && k < 60) begin
            step();
            k++;
        end
        fault_cyc = cyc;
        wd_go = go_cyc;
        check("wd_fault_set", fault, 1);
        check("wd_cycles_in_wait", fault_cyc - (wd_go + 1), TO);
        set_n(0, 6'd3);
        bus.req[0] = 1'b1;
        repeat (20) step();
        check("wd_no_resp", served_q.size(), base);
        check("wd_sticky", fault, 1);

        // Reset during WAIT, then a clean job
        do_reset();
        core_dead = 1'b0;
        core_lat  = 10;
        set_n(3, 6'd12);
        bus.req[3] = 1'b1;
        k = 0;
        while (!job_act && k < 10) begin
            step();
            k++;
        end
        check("rst_job_started", job_act, 1);
        repeat (5) step();
        #2 rst = 1'b1;
        bus.req = '0;
        #1 check_zero("rst_async");
        reset_model();
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        core_lat = 3;
        set_n(1, 6'd20);
        bus.req[1] = 1'b1;
        wait_resp("post_rst", 40);
        check("post_rst_id", served_q[$], 1);
        check("post_rst_result", res_q[$], 6765);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1);
    end
endmodule
